traffic_light_intersection: RTL and testbench

Parametrised two-direction (NS/EW) intersection controller, the next generation of the single-approach RED/GREEN/YELLOW sequencer. Adds all-red clearance, a tick-enable for prescaled timing, a latched pedestrian walk phase, and a flashing-yellow maintenance mode. Sits between the system prescaler (drives `en`) and the lamp/walk-signal drivers.

---
 rtl/traffic_light_intersection.sv | 147 ++++++++++++++
 tb/tb_traffic_light_intersection.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_intersection.sv
// Two-direction (NS/EW) intersection controller with all-red clearance, tick-enable timing,
// flashing-yellow maintenance mode and an optional pedestrian walk phase (macro TLC_PED_WALK_EN).
module traffic_light_intersection #(
  parameter int CNT_W    = 8,
  parameter int T_GREEN  = 15,
  parameter int T_YELLOW = 5,
  parameter int T_CLR    = 2,
  parameter int T_WALK   = 10
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             en,
  input  logic             flash,
  input  logic             ped_req,
  output logic             ns_red,
  output logic             ns_yellow,
  output logic             ns_green,
  output logic             ew_red,
  output logic             ew_yellow,
  output logic             ew_green,
  output logic             walk,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] t_remain
);

  typedef enum logic [2:0] {
    NS_G   = 3'd0,
    NS_Y   = 3'd1,
    ALL_R1 = 3'd2,
    EW_G   = 3'd3,
    EW_Y   = 3'd4,
    ALL_R2 = 3'd5,
    WALK   = 3'd6,
    FLASH  = 3'd7
  } phase_t;

  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_CLR    = CNT_W'(T_CLR - 1);
`ifdef TLC_PED_WALK_EN
  localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(T_WALK - 1);
`endif

  phase_t           ph, ph_nxt;
  logic [CNT_W-1:0] tmr, tmr_nxt;
  logic             blink, blink_nxt;
`ifdef TLC_PED_WALK_EN
  logic             ped_pend, ped_nxt;
`else
  logic             ped_req_unused;
  assign ped_req_unused = ped_req;
`endif

  // Lamp vector order: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}
  function automatic logic [6:0] lamp_dec(input phase_t p, input logic b);
    case (p)
      NS_G:    lamp_dec = 7'b0011000;
      NS_Y:    lamp_dec = 7'b0101000;
      EW_G:    lamp_dec = 7'b1000010;
      EW_Y:    lamp_dec = 7'b1000100;
      WALK:    lamp_dec = 7'b1001001;
      FLASH:   lamp_dec = {1'b0, b, 1'b0, 1'b0, b, 1'b0, 1'b0};
      default: lamp_dec = 7'b1001000;
    endcase
  endfunction

  always_comb begin
    ph_nxt    = ph;
    tmr_nxt   = tmr;
    blink_nxt = blink;
`ifdef TLC_PED_WALK_EN
    ped_nxt   = ped_pend;
`endif
    if (ph == FLASH) begin
      if (!flash) begin
        ph_nxt    = ALL_R2;
        tmr_nxt   = LD_CLR;
        blink_nxt = 1'b0;
      end else if (en) begin
        blink_nxt = ~blink;
      end
    end else if (flash) begin
      // Maintenance request overrides the timer, including a terminal tick in the same cycle
      ph_nxt    = FLASH;
      tmr_nxt   = '0;
      blink_nxt = 1'b1;
`ifdef TLC_PED_WALK_EN
      ped_nxt   = 1'b0;
`endif
    end else begin
`ifdef TLC_PED_WALK_EN
      if (ped_req && ph != WALK) ped_nxt = 1'b1;
`endif
      if (en) begin
        if (tmr != '0) begin
          tmr_nxt = tmr - CNT_W'(1);
        end else begin
          case (ph)
            NS_G:   begin ph_nxt = NS_Y;   tmr_nxt = LD_YELLOW; end
            NS_Y:   begin ph_nxt = ALL_R1; tmr_nxt = LD_CLR;    end
            ALL_R1: begin ph_nxt = EW_G;   tmr_nxt = LD_GREEN;  end
            EW_G:   begin ph_nxt = EW_Y;   tmr_nxt = LD_YELLOW; end
            EW_Y:   begin ph_nxt = ALL_R2; tmr_nxt = LD_CLR;    end
`ifdef TLC_PED_WALK_EN
            ALL_R2: begin
              // Decided on the latch value before this cycle's request; clear wins on WALK entry
              if (ped_pend) begin
                ph_nxt  = WALK;
                tmr_nxt = LD_WALK;
                ped_nxt = 1'b0;
              end else begin
                ph_nxt  = NS_G;
                tmr_nxt = LD_GREEN;
              end
            end
`endif
            default: begin ph_nxt = NS_G; tmr_nxt = LD_GREEN; end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      ph    <= ALL_R2;
      tmr   <= LD_CLR;
      blink <= 1'b0;
`ifdef TLC_PED_WALK_EN
      ped_pend <= 1'b0;
`endif
      {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk} <= 7'b1001000;
    end else begin
      ph    <= ph_nxt;
      tmr   <= tmr_nxt;
      blink <= blink_nxt;
`ifdef TLC_PED_WALK_EN
      ped_pend <= ped_nxt;
`endif
      {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk} <= lamp_dec(ph_nxt, blink_nxt);
    end
  end

  assign state    = ph;
  assign t_remain = tmr;

endmodule

// File: tb/tb_traffic_light_intersection.sv
// Directed self-checking bench for traffic_light_intersection: phase table walk, prescaled ticks,
// flash mode, asynchronous reset and pedestrian handling (either build of TLC_PED_WALK_EN).
module tb_traffic_light_intersection;

  logic       clk = 1'b0;
  logic       rs, en, flash, ped_req;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
  logic [2:0] state;
  logic [7:0] t_remain;

  int n_cmp = 0;
  int n_bad = 0;
  int seq_ph[$];
  int seq_d[$];
  int ped_cycles[$];
  bit ped_hold = 1'b0;

  traffic_light_intersection #(
    .CNT_W(8), .T_GREEN(15), .T_YELLOW(5), .T_CLR(2), .T_WALK(10)
  ) dut (
    .clk(clk), .rs(rs), .en(en), .flash(flash), .ped_req(ped_req),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk(walk), .state(state), .t_remain(t_remain)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}
  function automatic logic [6:0] exp_lamps(input int ph, input logic b);
    case (ph)
      0:       exp_lamps = 7'b0011000;
      1:       exp_lamps = 7'b0101000;
      2, 5:    exp_lamps = 7'b1001000;
      3:       exp_lamps = 7'b1000010;
      4:       exp_lamps = 7'b1000100;
      6:       exp_lamps = 7'b1001001;
      7:       exp_lamps = {1'b0, b, 1'b0, 1'b0, b, 1'b0, 1'b0};
      default: exp_lamps = 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] lamps_now();
    lamps_now = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int p, input int d);
    seq_ph.push_back(p);
    seq_d.push_back(d);
  endtask

  task automatic push_period();
    push(5, 2); push(0, 15); push(1, 5); push(2, 2); push(3, 15); push(4, 5);
  endtask

  task automatic do_reset();
    rs = 1'b1; en = 1'b0; flash = 1'b0; ped_req = 1'b0;
    tick();
    chk("rst_state", state, 5);
    chk("rst_tremain", t_remain, 1);
    chk("rst_lamps", lamps_now(), 7'b1001000);
    tick();
    rs = 1'b0;
    en = 1'b1;
    seq_ph.delete(); seq_d.delete(); ped_cycles.delete();
  endtask

  // Walk the expected phase table; each enabled tick is preceded by div-1 idle clocks
  task automatic run_seq(input int div, input int max_cyc);
    int cyc = 0;
    for (int k = 0; k < seq_ph.size(); k++) begin
      for (int i = 0; i < seq_d[k]; i++) begin
        for (int j = 0; j < div; j++) begin
          bit pr;
          if (cyc >= max_cyc) begin
            en = 1'b1; ped_req = 1'b0;
            return;
          end
          chk($sformatf("c%0d state", cyc), state, seq_ph[k]);
          chk($sformatf("c%0d t_remain", cyc), t_remain, seq_d[k] - 1 - i);
          chk($sformatf("c%0d lamps", cyc), lamps_now(), exp_lamps(seq_ph[k], 1'b0));
          pr = ped_hold;
          foreach (ped_cycles[q]) if (ped_cycles[q] == cyc) pr = 1'b1;
          ped_req = pr;
          en = (j == div - 1);
          tick();
          cyc++;
        end
      end
    end
    en = 1'b1;
    ped_req = 1'b0;
  endtask

  initial begin
    // Default timing, en constant: two 44-clock periods
    do_reset();
    push_period(); push_period(); push(5, 2);
    run_seq(1, 1000);

    // en high one clock in four: every dwell stretched x4, timer holds between ticks
    do_reset();
    push_period(); push(5, 2);
    run_seq(4, 1000);

`ifdef TLC_PED_WALK_EN
    // Request in NS_G served after the next ALL_R2; request during WALK ignored
    do_reset();
    push_period(); push(5, 2); push(6, 10);
    push(0, 15); push(1, 5); push(2, 2); push(3, 15); push(4, 5);
    push(5, 2); push(0, 15);
    ped_cycles.push_back(5);
    ped_cycles.push_back(49);
    run_seq(1, 1000);
`else
    // Requests have no effect in this build
    do_reset();
    ped_hold = 1'b1;
    push_period(); push_period(); push_period(); push_period(); push_period(); push(5, 2);
    run_seq(1, 1000);
    ped_hold = 1'b0;
`endif

    // Flash requested mid EW_G
    do_reset();
    push_period();
    run_seq(1, 30);
    chk("pre_flash_state", state, 3);
    chk("pre_flash_t", t_remain, 8);
    flash = 1'b1;
    tick();
    chk("flash_state", state, 7);
    chk("flash_t", t_remain, 0);
    chk("flash_lamps0", lamps_now(), exp_lamps(7, 1'b1));
    tick();
    chk("flash_lamps1", lamps_now(), exp_lamps(7, 1'b0));
    tick();
    chk("flash_lamps2", lamps_now(), exp_lamps(7, 1'b1));
    en = 1'b0;
    tick();
    chk("flash_hold", lamps_now(), exp_lamps(7, 1'b1));
    chk("flash_hold_t", t_remain, 0);
    en = 1'b1;
    tick();
    chk("flash_lamps3", lamps_now(), exp_lamps(7, 1'b0));
    flash = 1'b0;
    tick();
    seq_ph.delete(); seq_d.delete();
    push(5, 2); push(0, 15);
    run_seq(1, 6);

    // Asynchronous reset mid NS_Y with a pending request
    do_reset();
    push_period();
    ped_cycles.push_back(5);
    run_seq(1, 19);
    chk("pre_rst_state", state, 1);
    chk("pre_rst_t", t_remain, 2);
    ped_cycles.delete();
    #2 rs = 1'b1;
    #1;
    chk("async_state", state, 5);
    chk("async_t", t_remain, 1);
    chk("async_lamps", lamps_now(), 7'b1001000);
    #1 rs = 1'b0;
    seq_ph.delete(); seq_d.delete();
    push_period(); push_period(); push(5, 2);
    run_seq(1, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
